// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS requesters share one slave port.
// One owner holds the bus per cyc tenure. A watchdog turns a missing response into an err pulse.
module wb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS     = 4,
  parameter int unsigned C_WB_DATA_WIDTH = 32,
  parameter int unsigned C_WB_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                                         wb_clk_i,
  input  logic                                         wb_rst_n_i,
  input  logic [NUM_MASTERS-1:0]                       m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                       m_stb_i,
  input  logic [NUM_MASTERS-1:0]                       m_we_i,
  input  logic [NUM_MASTERS*(C_WB_DATA_WIDTH/8)-1:0]   m_sel_i,
  input  logic [NUM_MASTERS*C_WB_ADDR_WIDTH-1:0]       m_adr_i,
  input  logic [NUM_MASTERS*C_WB_DATA_WIDTH-1:0]       m_dat_i,
  output logic [C_WB_DATA_WIDTH-1:0]                   m_dat_o,
  output logic [NUM_MASTERS-1:0]                       m_ack_o,
  output logic [NUM_MASTERS-1:0]                       m_err_o,
  output logic                                         s_cyc_o,
  output logic                                         s_stb_o,
  output logic                                         s_we_o,
  output logic [C_WB_DATA_WIDTH/8-1:0]                 s_sel_o,
  output logic [C_WB_ADDR_WIDTH-1:0]                   s_adr_o,
  output logic [C_WB_DATA_WIDTH-1:0]                   s_dat_o,
  input  logic [C_WB_DATA_WIDTH-1:0]                   s_dat_i,
  input  logic                                         s_ack_i,
  input  logic                                         s_err_i,
  output logic [NUM_MASTERS-1:0]                       grant_o
);

  localparam int unsigned SW = C_WB_DATA_WIDTH / 8;
  localparam int unsigned AW = C_WB_ADDR_WIDTH;
  localparam int unsigned DW = C_WB_DATA_WIDTH;
  localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IW-1:0]          ptr_q, owner_q;
  logic [CW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic [IW-1:0]          ptr_d, pick_idx, cand;
  logic                   pick_valid;
  logic                   owned, owner_cyc, stb_wait, tmo_pulse;

  assign owned     = (state_q == OWNED);
  assign owner_cyc = m_cyc_i[owner_q];
  // Watchdog condition is built from the inputs, not s_stb_o, to keep the comb paths acyclic.
  assign stb_wait  = owned & owner_cyc & m_stb_i[owner_q] & ~s_ack_i & ~s_err_i;
  assign tmo_pulse = (TIMEOUT_CYCLES != 0) && stb_wait && (tmo_cnt_q == TMO_LAST);
  assign ptr_d     = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
  assign tmo_cnt_d = (stb_wait && !tmo_pulse) ? tmo_cnt_q + 1'b1 : '0;
  assign grant_o   = grant_q;
  assign m_dat_o   = s_dat_i;

  // First requester found scanning ptr, ptr+1, ... modulo NUM_MASTERS.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      cand = IW'((32'(ptr_q) + i) % NUM_MASTERS);
      if (!pick_valid && m_cyc_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      tmo_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tmo_cnt_q <= '0;
          if (pick_valid) begin
            state_q <= OWNED;
            owner_q <= pick_idx;
            grant_q <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
          end
        end
        OWNED: begin
          if (!owner_cyc) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= ptr_d;
            tmo_cnt_q <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (owned) begin
      s_cyc_o          = owner_cyc;
      s_stb_o          = m_stb_i[owner_q] & owner_cyc;
      s_we_o           = m_we_i[owner_q];
      s_sel_o          = m_sel_i[owner_q*SW +: SW];
      s_adr_o          = m_adr_i[owner_q*AW +: AW];
      s_dat_o          = m_dat_i[owner_q*DW +: DW];
      m_ack_o[owner_q] = s_ack_i;
      m_err_o[owner_q] = s_err_i | tmo_pulse;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: 4 masters, 32-bit bus, watchdog limit 8.
`timescale 1ns/1ps
module tb_wb_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic            clk, rst_n;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*SW-1:0] m_sel;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack, m_err, grant;
  logic            s_cyc, s_stb, s_we;
  logic [SW-1:0]   s_sel;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_o, s_dat_i;
  logic            s_ack, s_err;

  int tests = 0;
  int fails = 0;

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .C_WB_DATA_WIDTH(DW), .C_WB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_cyc = '1; m_stb = '1; s_ack = 1'b1; s_err = 1'b1;
    #3;
    tests++;
    if (grant !== 4'b0000) begin $display("FAIL reset_grant: got %b exp 0000", grant); fails++; end
    tests++;
    if ({s_cyc, s_stb} !== 2'b00) begin $display("FAIL reset_s_cyc_stb: got %b exp 00", {s_cyc, s_stb}); fails++; end
    tests++;
    if ({m_ack, m_err} !== 8'h00) begin $display("FAIL reset_ack_err: got %h exp 00", {m_ack, m_err}); fails++; end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
    m_adr[0 +: AW] = 32'h0; m_dat[0 +: DW] = 32'hDEADBEEF; m_sel[0 +: SW] = 4'hF;
    s_dat_i = 32'h12345678;
    @(negedge clk);
    tests++;
    if (grant !== 4'b0000) begin $display("FAIL single_pre_grant: got %b exp 0000", grant); fails++; end
    tick();
    tests++;
    if (grant !== 4'b0001) begin $display("FAIL single_grant: got %b exp 0001", grant); fails++; end
    tests++;
    if ({s_cyc, s_stb, s_we, s_sel} !== 7'b111_1111) begin
      $display("FAIL single_ctrl: got %b exp 1111111", {s_cyc, s_stb, s_we, s_sel}); fails++;
    end
    tests++;
    if (s_dat_o !== 32'hDEADBEEF) begin $display("FAIL single_s_dat: got %h exp deadbeef", s_dat_o); fails++; end
    tests++;
    if (s_adr !== 32'h0) begin $display("FAIL single_s_adr: got %h exp 0", s_adr); fails++; end
    tests++;
    if (m_dat_o !== 32'h12345678) begin $display("FAIL single_m_dat: got %h exp 12345678", m_dat_o); fails++; end
    tick();
    s_ack = 1'b1;
    @(negedge clk);
    tests++;
    if (m_ack !== 4'b0001) begin $display("FAIL single_ack: got %b exp 0001", m_ack); fails++; end
    tick();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge clk);
    tests++;
    if ({m_ack, s_cyc} !== 5'b0000_0) begin $display("FAIL single_ack_drop: got %b exp 00000", {m_ack, s_cyc}); fails++; end
    tick();
    tests++;
    if (grant !== 4'b0000) begin $display("FAIL single_release: got %b exp 0000", grant); fails++; end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    do_reset();
    m_cyc = 4'b1111; m_stb = 4'b1111;
    tick();
    for (int k = 0; k < N; k++) begin
      exp_g = 4'b0001 << k;
      s_ack = 1'b1;
      @(negedge clk);
      tests++;
      if (grant !== exp_g) begin $display("FAIL rr_grant[%0d]: got %b exp %b", k, grant, exp_g); fails++; end
      tests++;
      if (m_ack !== exp_g) begin $display("FAIL rr_ack[%0d]: got %b exp %b", k, m_ack, exp_g); fails++; end
      tick();
      s_ack = 1'b0; m_stb[k] = 1'b0;
      tick();
      tests++;
      if (grant !== exp_g) begin $display("FAIL rr_hold[%0d]: got %b exp %b", k, grant, exp_g); fails++; end
      tick();
      m_cyc[k] = 1'b0;
      tick();
      tests++;
      if (grant !== 4'b0000) begin $display("FAIL rr_idle[%0d]: got %b exp 0000", k, grant); fails++; end
      tick();
    end
    tests++;
    if (grant !== 4'b0000) begin $display("FAIL rr_final_idle: got %b exp 0000", grant); fails++; end
  endtask

  task automatic test_fairness();
    do_reset();
    m_cyc[0] = 1'b1;
    tick();
    m_cyc[2] = 1'b1;
    tick();
    tests++;
    if (grant !== 4'b0001) begin $display("FAIL fair_no_preempt: got %b exp 0001", grant); fails++; end
    m_cyc[0] = 1'b0;
    tick();
    m_cyc[0] = 1'b1;
    tests++;
    if (grant !== 4'b0000) begin $display("FAIL fair_idle: got %b exp 0000", grant); fails++; end
    tick();
    tests++;
    if (grant !== 4'b0100) begin $display("FAIL fair_m2_first: got %b exp 0100", grant); fails++; end
    m_cyc[2] = 1'b0;
    tick();
    tick();
    tests++;
    if (grant !== 4'b0001) begin $display("FAIL fair_m0_next: got %b exp 0001", grant); fails++; end
    m_cyc = '0;
    tick();
  endtask

  task automatic test_timeout();
    logic [N-1:0] exp_err, exp_ack;
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    for (int c = 1; c <= 32; c++) begin
      s_ack = (c == 32);
      exp_err = ((c % 8) == 0 && c != 32) ? 4'b0010 : 4'b0000;
      exp_ack = (c == 32) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      tests++;
      if (m_err !== exp_err) begin $display("FAIL tmo_err[c=%0d]: got %b exp %b", c, m_err, exp_err); fails++; end
      if (c == 32) begin
        tests++;
        if (m_ack !== exp_ack) begin $display("FAIL tmo_ack_wins: got %b exp %b", m_ack, exp_ack); fails++; end
      end
      tick();
    end
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
    tick();
    tests++;
    if (grant !== 4'b1000) begin $display("FAIL arst_owner: got %b exp 1000", grant); fails++; end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({grant, s_cyc} !== 5'b0000_0) begin $display("FAIL arst_clear: got %b exp 00000", {grant, s_cyc}); fails++; end
    @(negedge clk);
    rst_n = 1'b1;
    m_cyc[0] = 1'b1;
    tick();
    tests++;
    if (grant !== 4'b0001) begin $display("FAIL arst_m0_prio: got %b exp 0001", grant); fails++; end
    m_cyc = '0; m_stb = '0;
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    tick();
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    @(negedge clk);
    tests++;
    if ({s_cyc, s_stb} !== 2'b00) begin $display("FAIL abort_s_cyc: got %b exp 00", {s_cyc, s_stb}); fails++; end
    tests++;
    if (grant !== 4'b0100) begin $display("FAIL abort_grant_held: got %b exp 0100", grant); fails++; end
    tick();
    s_ack = 1'b1;
    @(negedge clk);
    tests++;
    if (m_ack !== 4'b0000) begin $display("FAIL abort_late_ack: got %b exp 0000", m_ack); fails++; end
    tests++;
    if (grant !== 4'b0000) begin $display("FAIL abort_grant_clear: got %b exp 0000", grant); fails++; end
    tick();
    s_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_fairness();
    test_timeout();
    test_async_reset();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
